// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: OV7670-style camera stream generator (v_sync/href/RGB565 bytes).
// One byte per clk. Optional build macro STREAM_GEN_BARS_EN swaps the x/y
// gradient pattern for 8 vertical colour bars; frame timing is unchanged.
// All outputs are registered: next values are computed from the next
// state/counters and loaded on the same edge as the state itself.
module ov7670_stream_gen #(
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       v_sync,
  output logic       href,
  output logic [7:0] data,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int unsigned L  = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HW = $clog2(L);
  localparam int unsigned LW = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VSYNC  = 3'd1;
  localparam logic [2:0] VBACK  = 3'd2;
  localparam logic [2:0] ACTIVE = 3'd3;
  localparam logic [2:0] VFRONT = 3'd4;

  logic [2:0]    state, state_n;
  logic [HW-1:0] h_cnt, h_n;
  logic [LW-1:0] line_cnt, line_n;
  logic [LW-1:0] last_line;
  logic          last_h;
  logic [7:0]    frame_n;
  logic          v_sync_n, href_n, busy_n;
  logic [7:0]    data_n;
  logic [8:0]    x;
  logic [15:0]   pix;

  // Next-state, byte counter, line counter and frame counter
  always_comb begin
    state_n   = state;
    h_n       = h_cnt;
    line_n    = line_cnt;
    frame_n   = frame_cnt;
    last_h    = (h_cnt == HW'(L - 1));
    last_line = '0;
    case (state)
      VSYNC:   last_line = LW'(VSYNC_LINES - 1);
      VBACK:   last_line = LW'(V_BACK - 1);
      ACTIVE:  last_line = LW'(V_ACTIVE - 1);
      VFRONT:  last_line = LW'(V_FRONT - 1);
      default: last_line = '0;
    endcase
    if (state == IDLE) begin
      h_n    = '0;
      line_n = '0;
      if (en) state_n = VSYNC;
    end else begin
      h_n = last_h ? '0 : h_cnt + HW'(1);
      if (last_h) begin
        if (line_cnt == last_line) begin
          line_n = '0;
          case (state)
            VSYNC:  state_n = VBACK;
            VBACK:  state_n = ACTIVE;
            ACTIVE: state_n = VFRONT;
            VFRONT: begin
              frame_n = frame_cnt + 8'd1;
              state_n = en ? VSYNC : IDLE;
            end
            default: state_n = IDLE;
          endcase
        end else begin
          line_n = line_cnt + LW'(1);
        end
      end
    end
  end

  // Pixel colour for the byte about to be emitted
`ifdef STREAM_GEN_BARS_EN
  logic [2:0] bar;
  always_comb begin
    x   = 9'(h_n >> 1);
    bar = 3'(x / 9'(H_ACTIVE / 8));
    pix = 16'h0000;
    case (bar)
      3'd0: pix = 16'hFFFF;
      3'd1: pix = 16'hFFE0;
      3'd2: pix = 16'h07FF;
      3'd3: pix = 16'h07E0;
      3'd4: pix = 16'hF81F;
      3'd5: pix = 16'hF800;
      3'd6: pix = 16'h001F;
      3'd7: pix = 16'h0000;
      default: pix = 16'h0000;
    endcase
  end
`else
  logic [7:0] y;
  always_comb begin
    x   = 9'(h_n >> 1);
    y   = 8'(line_n);
    pix = {x[8:4], y[7:2], x[4:0] ^ y[4:0]};
  end
`endif

  // Next output values derived from the next state and counters
  always_comb begin
    v_sync_n = (state_n == VSYNC);
    busy_n   = (state_n != IDLE);
    href_n   = (state_n == ACTIVE) && (h_n < HW'(2 * H_ACTIVE));
    data_n   = 8'h00;
    if (href_n) data_n = h_n[0] ? pix[7:0] : pix[15:8];
  end

  // State, counters and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      h_cnt     <= '0;
      line_cnt  <= '0;
      frame_cnt <= 8'h00;
      v_sync    <= 1'b0;
      href      <= 1'b0;
      data      <= 8'h00;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      h_cnt     <= h_n;
      line_cnt  <= line_n;
      frame_cnt <= frame_n;
      v_sync    <= v_sync_n;
      href      <= href_n;
      data      <= data_n;
      busy      <= busy_n;
    end
  end

endmodule
